// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and a constant log2 helper for counter sizing.
package arith_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Smallest r with 2**r >= v; used in constant expressions only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the only arithmetic element of the serial datapath.
// Purely combinational: zero latency, no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
// Latency WIDTH cycles of busy, then a one-cycle done; start is ignored while busy.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int              CW   = clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic             state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign res_next = {fa_s, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_c;
                    res   <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB on this bit
                        sum   <= res_next;
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        zero  <= (res_next == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed self-check of serial_addsub at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_addsub;

    logic        clk;
    logic        rst_n;

    logic        start8, sub8, busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, sub16, busy16, done16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, sum16;

    int vectors;
    int miscompares;
    logic [15:0] prev_sum [2];

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input bit s, input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] es, output logic ec, output logic eo,
                                  output logic ez);
        longint one, mask, ua, ub, sa, sb, r, smax, smin;
        one  = 1;
        mask = (one << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        r    = s ? sa - sb : sa + sb;
        smax = (one << (w - 1)) - 1;
        smin = -(one << (w - 1));
        es   = 16'((s ? ua - ub : ua + ub) & mask);
        ec   = s ? (ua >= ub) : (((ua + ub) >> w) != 0);
        eo   = (r > smax) || (r < smin);
        ez   = (es == 16'h0);
    endfunction

    task automatic drive(input bit w16, input logic st, input logic s, input logic [15:0] av,
                         input logic [15:0] bv);
        if (w16) begin
            start16 = st; sub16 = s; a16 = av; b16 = bv;
        end else begin
            start8 = st; sub8 = s; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    function automatic logic get_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction

    function automatic logic get_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction

    function automatic logic [15:0] get_sum(input bit w16);
        return w16 ? sum16 : {8'h00, sum8};
    endfunction

    function automatic logic [2:0] get_flags(input bit w16);
        return w16 ? {cout16, ovf16, zero16} : {cout8, ovf8, zero8};
    endfunction

    // One operation. no_wait: issue start in the current cycle (used in the done cycle).
    // inject: re-request with sub=1, a=b=all-ones during busy cycle 3; it must be ignored.
    task automatic run_op(input bit w16, input bit s, input logic [15:0] av, input logic [15:0] bv,
                          input bit no_wait, input bit inject, input bit tail);
        int w, bc;
        bit seen;
        logic [15:0] es;
        logic ec, eo, ez;
        w = w16 ? 16 : 8;
        model(w, s, av, bv, es, ec, eo, ez);
        if (!no_wait) @(negedge clk);
        drive(w16, 1'b1, s, av, bv);
        @(posedge clk); #1;
        drive(w16, 1'b0, ~s, ~av, ~bv);
        bc   = 0;
        seen = 0;
        for (int i = 0; i < w + 4 && !seen; i++) begin
            if (get_busy(w16)) begin
                bc++;
                chk("held_sum", {16'h0, get_sum(w16)}, {16'h0, prev_sum[w16]});
            end
            if (get_done(w16)) begin
                seen = 1;
            end else begin
                if (inject) drive(w16, bc == 3, 1'b1, 16'hFFFF, 16'hFFFF);
                @(posedge clk); #1;
            end
        end
        chk("done_seen", {31'h0, seen}, 32'h1);
        chk("busy_cycles", bc, w);
        chk("busy_low_at_done", {31'h0, get_busy(w16)}, 32'h0);
        chk("sum", {16'h0, get_sum(w16)}, {16'h0, es});
        chk("cout_ovf_zero", {29'h0, get_flags(w16)}, {29'h0, ec, eo, ez});
        prev_sum[w16] = es;
        if (tail) begin
            @(posedge clk); #1;
            chk("done_one_cycle", {31'h0, get_done(w16)}, 32'h0);
        end
    endtask

    initial begin
        int dn;
        vectors     = 0;
        miscompares = 0;
        prev_sum[0] = '0;
        prev_sum[1] = '0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs8", {busy8, done8, sum8, cout8, ovf8, zero8}, 32'h0);
        chk("reset_outs16", {busy16, done16, sum16, cout16, ovf16, zero16}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases at WIDTH=8
        run_op(1'b0, 1'b0, 16'h35, 16'h4A, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 16'h05, 16'h05, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 16'h03, 16'h05, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 16'h80, 16'h01, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 16'h5A, 16'h00, 1'b0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 16'h00, 16'h80, 1'b0, 1'b0, 1'b1);
        // Ignored mid-busy request, then back-to-back start in the done cycle
        run_op(1'b0, 1'b0, 16'h10, 16'h20, 1'b0, 1'b1, 1'b0);
        chk("ignored_req_sum", {24'h0, sum8}, 32'h30);
        run_op(1'b0, 1'b0, 16'h22, 16'h11, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of 7F+7F
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h7F, 16'h7F);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_reset_outs", {busy8, done8, sum8, cout8, ovf8, zero8}, 32'h0);
        prev_sum[0] = '0;
        prev_sum[1] = '0;
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        chk("no_done_after_reset", dn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 16'h01, 16'h02, 1'b0, 1'b0, 1'b1);

        // WIDTH=16 corner and random sweeps
        run_op(1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_op(1'b1, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 1000; k++)
            run_op(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 200; k++)
            run_op(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
